// File: rtl/uart_tx_fifo_rd_if.sv
// Read port of the TX asynchronous FIFO as seen from the rclk domain.
// The master modport is the UART transmit engine; the slave modport is the FIFO.
interface uart_tx_fifo_rd_if #(
    parameter int DATASIZEL = 8
);
    logic                 rinc;
    logic                 rempty;
    logic [DATASIZEL-1:0] rdata;

    modport master (output rinc, input rempty, input rdata);
    modport slave  (input rinc, output rempty, output rdata);
endinterface

// File: rtl/uart_tx_fifo_rd.sv
// UART transmit engine that pops bytes from the TX FIFO read port and serialises them on txd.
// Optional parity bit is enabled by defining UART_TX_PARITY_EN.
module uart_tx_fifo_rd #(
    parameter int DATASIZEL = 8,
    parameter int STOP_BITS = 1
`ifdef UART_TX_PARITY_EN
   ,parameter int PARITY_ODD = 0
`endif
) (
    input  logic              rclk,
    input  logic              rrst,
    input  logic              tx_en,
    input  logic [15:0]       baud_div,
    uart_tx_fifo_rd_if.master fifo,
    output logic              txd,
    output logic              tx_busy,
    output logic              tx_done
);

    localparam int BCW = $clog2(DATASIZEL) + 1;
    localparam logic [BCW-1:0] LAST_BIT  = BCW'(DATASIZEL - 1);
    localparam logic           LAST_STOP = 1'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t               state, state_nxt;
    logic [15:0]          baud_cnt, baud_cnt_nxt;
    logic [15:0]          frame_div, frame_div_nxt;
    logic [BCW-1:0]       bit_cnt, bit_cnt_nxt;
    logic                 stop_cnt, stop_cnt_nxt;
    logic [DATASIZEL-1:0] shreg, shreg_nxt;
    logic                 txd_nxt, rinc_nxt, busy_nxt, done_nxt;
    logic                 start_frame, bit_end;
`ifdef UART_TX_PARITY_EN
    logic                 parity_bit, parity_nxt;
`endif

    assign start_frame = tx_en && !fifo.rempty;
    assign bit_end     = (baud_cnt == frame_div);

    // All state and every output are registered here.
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            frame_div <= '0;
            bit_cnt   <= '0;
            stop_cnt  <= 1'b0;
            shreg     <= '0;
            txd       <= 1'b1;
            fifo.rinc <= 1'b0;
            tx_busy   <= 1'b0;
            tx_done   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            baud_cnt  <= baud_cnt_nxt;
            frame_div <= frame_div_nxt;
            bit_cnt   <= bit_cnt_nxt;
            stop_cnt  <= stop_cnt_nxt;
            shreg     <= shreg_nxt;
            txd       <= txd_nxt;
            fifo.rinc <= rinc_nxt;
            tx_busy   <= busy_nxt;
            tx_done   <= done_nxt;
`ifdef UART_TX_PARITY_EN
            parity_bit <= parity_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (start_frame) state_nxt = START;
            START:  if (bit_end) state_nxt = DATA;
            DATA: begin
                if (bit_end && bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                    state_nxt = PARITY;
`else
                    state_nxt = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (bit_end) state_nxt = STOP;
`endif
            STOP:   if (bit_end && stop_cnt == LAST_STOP) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The divisor and the byte are latched together at frame start, so
    // baud_div and rdata may change freely while the frame is on the line.
    always_comb begin
        baud_cnt_nxt  = bit_end ? 16'd0 : baud_cnt + 16'd1;
        frame_div_nxt = frame_div;
        bit_cnt_nxt   = bit_cnt;
        stop_cnt_nxt  = stop_cnt;
        shreg_nxt     = shreg;
        txd_nxt       = txd;
        rinc_nxt      = 1'b0;
        busy_nxt      = tx_busy;
        done_nxt      = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_nxt    = parity_bit;
`endif
        case (state)
            IDLE: begin
                baud_cnt_nxt = 16'd0;
                if (start_frame) begin
                    shreg_nxt     = fifo.rdata;
                    frame_div_nxt = baud_div;
                    bit_cnt_nxt   = '0;
                    stop_cnt_nxt  = 1'b0;
                    rinc_nxt      = 1'b1;
                    txd_nxt       = 1'b0;
                    busy_nxt      = 1'b1;
`ifdef UART_TX_PARITY_EN
                    parity_nxt    = (^fifo.rdata) ^ (PARITY_ODD != 0);
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    txd_nxt     = shreg[0];
                    shreg_nxt   = shreg >> 1;
                    bit_cnt_nxt = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        txd_nxt = parity_bit;
`else
                        txd_nxt = 1'b1;
`endif
                    end else begin
                        txd_nxt     = shreg[0];
                        shreg_nxt   = shreg >> 1;
                        bit_cnt_nxt = bit_cnt + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) txd_nxt = 1'b1;
            end
`endif
            STOP: begin
                if (bit_end) begin
                    if (stop_cnt == LAST_STOP) begin
                        done_nxt = 1'b1;
                        busy_nxt = 1'b0;
                    end else begin
                        stop_cnt_nxt = 1'b1;
                    end
                end
            end
            default: begin
                txd_nxt  = 1'b1;
                busy_nxt = 1'b0;
            end
        endcase
    end

endmodule
